// File: rtl/bcd_sched_pkg.sv
// Shared types and constants for the time-shared binary-to-BCD converter.
package bcd_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int WIDTH_DEF  = 14;
   localparam int DIGITS_DEF = 4;

   // Largest value representable with the given number of decimal digits.
   function automatic longint max_dec(input int digits);
      longint r;
      r = 1;
      for (int i = 0; i < digits; i++) begin
         r = r * 10;
      end
      return r - 1;
   endfunction

   localparam longint MAX_DEC = max_dec(DIGITS_DEF);

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD digit >= 5, then shift
// the concatenation {bcd, bin} left by one bit.
module bcd_dabble_step #(
   parameter int DIGITS = 4,
   parameter int WIDTH  = 14
) (
   input  logic [4*DIGITS-1:0] bcd,
   input  logic [WIDTH-1:0]    bin,
   output logic [4*DIGITS-1:0] bcd_next,
   output logic [WIDTH-1:0]    bin_next
);

   logic [4*DIGITS-1:0] adj;

   // Per-digit correction so that the following shift carries correctly into the next digit.
   always_comb begin
      adj = bcd;
      for (int d = 0; d < DIGITS; d++) begin
         if (bcd[4*d +: 4] >= 4'd5) begin
            adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
         end
      end
   end

   assign {bcd_next, bin_next} = {adj, bin} << 1;

endmodule

// File: rtl/bcd_conv_sched.sv
// Two requesters share one iterative double-dabble converter, arbitrated
// round-robin. Each conversion takes WIDTH shift cycles plus one DONE cycle.
module bcd_conv_sched
   import bcd_sched_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int DIGITS = DIGITS_DEF
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [1:0]          i_req,
   input  logic [WIDTH-1:0]    i_bin0,
   input  logic [WIDTH-1:0]    i_bin1,
   output logic [1:0]          o_ack,
   output logic [4*DIGITS-1:0] o_bcd,
   output logic                o_ovf,
   output logic                o_busy,
   output logic                o_gnt
);

   localparam int              CW        = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]   LAST_STEP = CW'(WIDTH - 1);
   localparam longint          MAX_L     = max_dec(DIGITS);
   localparam bit              CAN_OVF   = (MAX_L < (longint'(1) << WIDTH));
   localparam logic [WIDTH-1:0] MAX_OP   = WIDTH'(MAX_L);

   state_t              state;
   logic [CW-1:0]       step_cnt;
   logic [4*DIGITS-1:0] bcd_acc;
   logic [WIDTH-1:0]    bin_sr;
   logic                ovf_pend;
   logic                last_gnt;

   logic                grant;
   logic [WIDTH-1:0]    sel_bin;
   logic                over;
   logic [WIDTH-1:0]    clamped;
   logic [4*DIGITS-1:0] bcd_nxt;
   logic [WIDTH-1:0]    bin_nxt;

   // Round-robin pick plus operand selection and clamping for the accept cycle.
   always_comb begin
      case (i_req)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         default: grant = ~last_gnt;
      endcase
      sel_bin = grant ? i_bin1 : i_bin0;
      over    = CAN_OVF && (sel_bin > MAX_OP);
      clamped = over ? MAX_OP : sel_bin;
   end

   bcd_dabble_step #(
      .DIGITS (DIGITS),
      .WIDTH  (WIDTH)
   ) u_step (
      .bcd      (bcd_acc),
      .bin      (bin_sr),
      .bcd_next (bcd_nxt),
      .bin_next (bin_nxt)
   );

   // Conversion sequencer; all outputs are registered and held between conversions.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= IDLE;
         step_cnt <= '0;
         bcd_acc  <= '0;
         bin_sr   <= '0;
         ovf_pend <= 1'b0;
         last_gnt <= 1'b1;
         o_ack    <= '0;
         o_bcd    <= '0;
         o_ovf    <= 1'b0;
         o_busy   <= 1'b0;
         o_gnt    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|i_req) begin
                  o_gnt    <= grant;
                  last_gnt <= grant;
                  bin_sr   <= clamped;
                  ovf_pend <= over;
                  bcd_acc  <= '0;
                  step_cnt <= '0;
                  o_busy   <= 1'b1;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               bcd_acc <= bcd_nxt;
               bin_sr  <= bin_nxt;
               if (step_cnt == LAST_STEP) begin
                  o_bcd <= bcd_nxt;
                  o_ovf <= ovf_pend;
                  o_ack <= o_gnt ? 2'b10 : 2'b01;
                  state <= DONE;
               end else begin
                  step_cnt <= step_cnt + 1'b1;
               end
            end
            DONE: begin
               o_ack  <= '0;
               o_busy <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               o_ack  <= '0;
               o_busy <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule
